// File: rtl/camera_pkg.sv
// camera_pkg: shared state type, exposure limits and readout schedule for the camera core.
package camera_pkg;
  typedef enum logic [1:0] {IDLE, EXPOSE, READOUT} state_t;
  localparam logic [4:0] EXP_MIN = 5'd2, EXP_MAX = 5'd30, EXP_RESET = 5'd2;
  localparam logic [2:0] NRE1_FIRST = 3'd0, NRE1_LAST = 3'd2, ADC1_AT = 3'd1,
                         NRE2_FIRST = 3'd4, NRE2_LAST = 3'd6, ADC2_AT = 3'd5, RC_LAST = 3'd7;
  function automatic logic in_span(input logic [2:0] rc, input logic [2:0] lo, input logic [2:0] hi);
    return rc >= lo && rc <= hi;
  endfunction
endpackage

// File: rtl/exposure_readout_ctrl_if.sv
// exposure_readout_ctrl_if: request/button/timer inputs and pixel/ADC/timer outputs of the controller.
interface exposure_readout_ctrl_if;
  logic init, exp_increase, exp_decrease, ovf5;
  logic start, erase, expose, nre_1, nre_2, adc;
  logic [4:0] exp_time;
  modport master(output init, exp_increase, exp_decrease, ovf5,
                 input start, exp_time, erase, expose, nre_1, nre_2, adc);
  modport slave(input init, exp_increase, exp_decrease, ovf5,
                output start, exp_time, erase, expose, nre_1, nre_2, adc);
endinterface

// File: rtl/exposure_time_reg.sv
// exposure_time_reg: saturating up/down exposure time register, frozen while hold is high.
import camera_pkg::*;
module exposure_time_reg #(
  parameter logic [4:0] LO = EXP_MIN,
  parameter logic [4:0] HI = EXP_MAX,
  parameter logic [4:0] INIT = EXP_RESET
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       hold,
  output logic [4:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= INIT;
    else if (!hold) q <= (inc && !dec && q < HI) ? q + 5'd1 : (dec && !inc && q > LO) ? q - 5'd1 : q;
endmodule

// File: rtl/exposure_readout_ctrl.sv
// exposure_readout_ctrl: capture FSM that starts the exposure timer, waits for overflow,
// then sequences the two-row pixel readout with ADC strobes.
import camera_pkg::*;
module exposure_readout_ctrl (
  input logic clk,
  input logic rst,
  exposure_readout_ctrl_if.slave bus
);
  state_t state;
  logic [2:0] rc, ro;
  logic init_q, init_rise, nre1_d, nre2_d, adc_d;
  assign init_rise = bus.init && !init_q;
  // Readout outputs are registered, so decode the rc value being entered this edge.
  assign ro = (state == READOUT) ? rc + 3'd1 : 3'd0;
  assign nre1_d = !in_span(ro, NRE1_FIRST, NRE1_LAST);
  assign nre2_d = !in_span(ro, NRE2_FIRST, NRE2_LAST);
  assign adc_d = ro == ADC1_AT || ro == ADC2_AT;
  exposure_time_reg u_exp (
    .clk(clk), .rst(rst), .inc(bus.exp_increase), .dec(bus.exp_decrease),
    .hold(state != IDLE || init_rise), .q(bus.exp_time)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rc <= 3'd0;
      init_q <= 1'b0;
      bus.start <= 1'b0;
      bus.erase <= 1'b1;
      bus.expose <= 1'b0;
      bus.nre_1 <= 1'b1;
      bus.nre_2 <= 1'b1;
      bus.adc <= 1'b0;
    end else begin
      init_q <= bus.init;
      bus.start <= 1'b0;
      case (state)
        IDLE: if (init_rise) begin
          state <= EXPOSE;
          bus.start <= 1'b1;
          bus.erase <= 1'b0;
          bus.expose <= 1'b1;
        end
        EXPOSE: if (bus.ovf5) begin
          state <= READOUT;
          rc <= 3'd0;
          bus.expose <= 1'b0;
          bus.nre_1 <= nre1_d;
          bus.nre_2 <= nre2_d;
          bus.adc <= adc_d;
        end
        READOUT: if (rc == RC_LAST) begin
          state <= IDLE;
          rc <= 3'd0;
          bus.erase <= 1'b1;
          bus.nre_1 <= 1'b1;
          bus.nre_2 <= 1'b1;
          bus.adc <= 1'b0;
        end else begin
          rc <= ro;
          bus.nre_1 <= nre1_d;
          bus.nre_2 <= nre2_d;
          bus.adc <= adc_d;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_exposure_readout_ctrl.sv
// tb_exposure_readout_ctrl: scenario tasks plus a randomized capture loop checked against
// a phase-based reference of the output pattern and an arithmetic exposure-time model.
module tb_exposure_readout_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  int compared = 0, mismatched = 0, exp_m = 2;
  localparam int P_IDLE = -1, P_START = -2, P_EXPO = -3;
  exposure_readout_ctrl_if bus();
  exposure_readout_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // {start, expose, erase, nre_1, nre_2, adc}; p >= 0 is the readout cycle index
  function automatic logic [5:0] ref_out(input int p);
    if (p == P_IDLE) return 6'b001110;
    if (p == P_START) return 6'b110110;
    if (p == P_EXPO) return 6'b010110;
    return {3'b000, !(p <= 2), !(p >= 4 && p <= 6), (p == 1 || p == 5)};
  endfunction

  function automatic logic [5:0] outs();
    return {bus.start, bus.expose, bus.erase, bus.nre_1, bus.nre_2, bus.adc};
  endfunction

  function automatic int adj(input int e, input logic u, input logic d);
    if (u && !d) return (e < 30) ? e + 1 : 30;
    if (d && !u) return (e > 2) ? e - 1 : 2;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i, input logic u, input logic d, input logic o);
    bus.init = i;
    bus.exp_increase = u;
    bus.exp_decrease = d;
    bus.ovf5 = o;
  endtask

  task automatic test_reset();
    drive(0, 1, 0, 1);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.init = ~bus.init;
      step();
      compared++;
      if (outs() !== ref_out(P_IDLE) || bus.exp_time !== 5'd2) begin
        mismatched++;
        $display("FAIL reset[%0d]: outs=%b exp_time=%0d, want %b exp_time=2", c, outs(), bus.exp_time, ref_out(P_IDLE));
      end
    end
    drive(0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    compared++;
    if (outs() !== ref_out(P_IDLE) || bus.exp_time !== 5'd2) begin
      mismatched++;
      $display("FAIL reset_release: outs=%b exp_time=%0d, want %b exp_time=2", outs(), bus.exp_time, ref_out(P_IDLE));
    end
    exp_m = 2;
  endtask

  task automatic test_exp_adjust();
    for (int c = 0; c < 46; c++) begin
      logic u, d;
      u = c < 40 || c >= 43;
      d = c >= 40;
      drive(0, u, d, 0);
      step();
      exp_m = adj(exp_m, u, d);
      compared++;
      if (bus.exp_time !== 5'(exp_m) || outs() !== ref_out(P_IDLE)) begin
        mismatched++;
        $display("FAIL exp_adjust[%0d]: exp_time=%0d outs=%b, want %0d %b", c, bus.exp_time, outs(), exp_m, ref_out(P_IDLE));
      end
    end
    compared++;
    if (bus.exp_time !== 5'd27) begin
      mismatched++;
      $display("FAIL exp_adjust_final: exp_time=%0d, want 27", bus.exp_time);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_capture_timing();
    for (int c = 1; c <= 30; c++) begin
      int p;
      drive(c == 10, 0, 0, c == 20);
      step();
      p = c < 10 ? P_IDLE : c == 10 ? P_START : c < 20 ? P_EXPO : c < 28 ? c - 20 : P_IDLE;
      compared++;
      if (outs() !== ref_out(p) || bus.exp_time !== 5'(exp_m)) begin
        mismatched++;
        $display("FAIL capture_timing edge %0d: outs=%b exp_time=%0d, want %b %0d", c, outs(), bus.exp_time, ref_out(p), exp_m);
      end
    end
  endtask

  task automatic test_init_held();
    int starts = 0;
    for (int c = 1; c <= 50; c++) begin
      int p;
      drive(1, 0, 0, c == 6);
      step();
      p = c == 1 ? P_START : c < 6 ? P_EXPO : c < 14 ? c - 6 : P_IDLE;
      starts += int'(bus.start);
      compared++;
      if (outs() !== ref_out(p)) begin
        mismatched++;
        $display("FAIL init_held edge %0d: outs=%b, want %b", c, outs(), ref_out(p));
      end
    end
    compared++;
    if (starts != 1) begin
      mismatched++;
      $display("FAIL init_held_starts: got %0d start pulses, want 1", starts);
    end
    drive(0, 0, 0, 0);
    step();
  endtask

  task automatic test_ignored_inputs();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 1);
      step();
      compared++;
      if (outs() !== ref_out(P_IDLE)) begin
        mismatched++;
        $display("FAIL ovf_in_idle[%0d]: outs=%b, want %b", c, outs(), ref_out(P_IDLE));
      end
    end
    drive(1, 0, 0, 0);
    step();
    for (int c = 1; c <= 6; c++) begin
      drive(c[0], 1, 0, 0);
      step();
      compared++;
      if (outs() !== ref_out(P_EXPO) || bus.exp_time !== 5'(exp_m)) begin
        mismatched++;
        $display("FAIL expose_ignores[%0d]: outs=%b exp_time=%0d, want %b %0d", c, outs(), bus.exp_time, ref_out(P_EXPO), exp_m);
      end
    end
    for (int j = 0; j <= 8; j++) begin
      drive(0, 0, 0, j == 0);
      step();
      compared++;
      if (outs() !== ref_out(j == 8 ? P_IDLE : j)) begin
        mismatched++;
        $display("FAIL ignored_readout[%0d]: outs=%b, want %b", j, outs(), ref_out(j == 8 ? P_IDLE : j));
      end
    end
  endtask

  task automatic test_init_priority();
    drive(1, 1, 0, 0);
    step();
    compared++;
    if (outs() !== ref_out(P_START) || bus.exp_time !== 5'(exp_m)) begin
      mismatched++;
      $display("FAIL init_priority: outs=%b exp_time=%0d, want %b %0d", outs(), bus.exp_time, ref_out(P_START), exp_m);
    end
    for (int j = 0; j <= 8; j++) begin
      drive(0, 0, 0, j == 0);
      step();
    end
    compared++;
    if (outs() !== ref_out(P_IDLE) || bus.exp_time !== 5'(exp_m)) begin
      mismatched++;
      $display("FAIL init_priority_done: outs=%b exp_time=%0d, want %b %0d", outs(), bus.exp_time, ref_out(P_IDLE), exp_m);
    end
  endtask

  task automatic test_reset_mid_readout();
    drive(0, 1, 0, 0);
    repeat (2) begin
      step();
      exp_m = adj(exp_m, 1, 0);
    end
    drive(1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0);
    repeat (3) step();
    for (int j = 0; j <= 4; j++) begin
      drive(0, 0, 0, j == 0);
      step();
    end
    compared++;
    if (outs() !== ref_out(4)) begin
      mismatched++;
      $display("FAIL pre_abort_rc4: outs=%b, want %b", outs(), ref_out(4));
    end
    rst = 1'b1;
    #1;
    exp_m = 2;
    compared++;
    if (outs() !== ref_out(P_IDLE) || bus.exp_time !== 5'(exp_m)) begin
      mismatched++;
      $display("FAIL async_abort: outs=%b exp_time=%0d, want %b %0d", outs(), bus.exp_time, ref_out(P_IDLE), exp_m);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    compared++;
    if (outs() !== ref_out(P_IDLE) || bus.exp_time !== 5'(exp_m)) begin
      mismatched++;
      $display("FAIL after_abort: outs=%b exp_time=%0d, want %b %0d", outs(), bus.exp_time, ref_out(P_IDLE), exp_m);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int e, l;
      logic u, d;
      e = int'($urandom_range(12, 1));
      l = int'($urandom_range(6, 1));
      drive(1, 1'($urandom), 1'($urandom), 1'($urandom));
      step();
      compared++;
      if (outs() !== ref_out(P_START) || bus.exp_time !== 5'(exp_m)) begin
        mismatched++;
        $display("FAIL rnd%0d start: outs=%b exp_time=%0d, want %b %0d", it, outs(), bus.exp_time, ref_out(P_START), exp_m);
      end
      for (int j = 1; j < e; j++) begin
        drive(1'($urandom), 1'($urandom), 1'($urandom), 0);
        step();
        compared++;
        if (outs() !== ref_out(P_EXPO) || bus.exp_time !== 5'(exp_m)) begin
          mismatched++;
          $display("FAIL rnd%0d expose%0d: outs=%b exp_time=%0d, want %b %0d", it, j, outs(), bus.exp_time, ref_out(P_EXPO), exp_m);
        end
      end
      for (int j = 0; j <= 8; j++) begin
        drive(0, j < 8 ? 1'($urandom) : 1'b0, j < 8 ? 1'($urandom) : 1'b0, j == 0 ? 1'b1 : 1'($urandom));
        step();
        compared++;
        if (outs() !== ref_out(j == 8 ? P_IDLE : j) || bus.exp_time !== 5'(exp_m)) begin
          mismatched++;
          $display("FAIL rnd%0d readout%0d: outs=%b exp_time=%0d, want %b %0d", it, j, outs(), bus.exp_time, ref_out(j == 8 ? P_IDLE : j), exp_m);
        end
      end
      for (int j = 0; j < l; j++) begin
        u = 1'($urandom);
        d = 1'($urandom);
        drive(0, u, d, 1'($urandom));
        step();
        exp_m = adj(exp_m, u, d);
        compared++;
        if (outs() !== ref_out(P_IDLE) || bus.exp_time !== 5'(exp_m)) begin
          mismatched++;
          $display("FAIL rnd%0d idle%0d: outs=%b exp_time=%0d, want %b %0d", it, j, outs(), bus.exp_time, ref_out(P_IDLE), exp_m);
        end
      end
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_exp_adjust();
    test_capture_timing();
    test_init_held();
    test_ignored_inputs();
    test_init_priority();
    test_reset_mid_readout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
